// File: rtl/led_fade_pkg.sv
// ============================================================================
// Module : led_fade_pkg
// Brief  : Shared constants and level type for the LED fade driver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package led_fade_pkg;

  localparam int c_PWM_BITS_DEFAULT = 4;
  localparam int c_LEVEL_W          = c_PWM_BITS_DEFAULT;
  localparam logic [c_LEVEL_W-1:0] c_LEVEL_MAX = {c_LEVEL_W{1'b1}};

  typedef logic [c_LEVEL_W-1:0] level_t;

  // Full-brightness level for an arbitrary brightness width.
  function automatic int level_max(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_fade_channel.sv
// ============================================================================
// Module : led_fade_channel
// Brief  : One LED channel: brightness level with trailing fade and PWM
//          compare. Macro LED_FADE_GAMMA_EN selects a squared duty curve.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS = c_PWM_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_pattern,
  input  logic                i_fade_en,
  input  logic                i_fade_tick,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_led
);

  localparam logic [PWM_BITS-1:0] c_MAX = PWM_BITS'(level_max(PWM_BITS));

  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] w_duty;
  logic                r_led;

  // A set pattern bit always wins, so a restart ignores a coincident tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= '0;
    end else if (i_pattern) begin
      r_level <= c_MAX;
    end else if (!i_fade_en) begin
      r_level <= '0;
    end else if (i_fade_tick && (r_level != '0)) begin
      r_level <= r_level - PWM_BITS'(1);
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_square;
  assign w_square = {{PWM_BITS{1'b0}}, r_level} * {{PWM_BITS{1'b0}}, r_level};
  assign w_duty   = PWM_BITS'(w_square >> PWM_BITS);
`else
  assign w_duty   = r_level;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led <= 1'b0;
    end else begin
      r_led <= (r_level == c_MAX) || (w_duty > i_pwm_cnt);
    end
  end

  assign o_led = r_led;

endmodule

`default_nettype wire

// File: rtl/led_fade_driver.sv
// ============================================================================
// Module : led_fade_driver
// Brief  : Multi-channel LED PWM driver with trailing fade; shared PWM counter
//          and fade prescaler. Macro LED_FADE_GAMMA_EN enables gamma duty.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = c_PWM_BITS_DEFAULT,
  parameter int FADE_DIV = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] pattern_in,
  input  logic                fade_en,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam int c_PRESC_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(FADE_DIV - 1);

  logic [PWM_BITS-1:0]  r_pwm_cnt;
  logic [c_PRESC_W-1:0] r_presc;
  logic                 w_fade_tick;

  // Tick marks the edge on which the prescaler wraps back to zero.
  assign w_fade_tick = (r_presc == c_PRESC_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
      r_presc   <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      r_presc   <= w_fade_tick ? '0 : r_presc + c_PRESC_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
      led_fade_channel #(
        .PWM_BITS (PWM_BITS)
      ) u_ch (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_pattern   (pattern_in[gi]),
        .i_fade_en   (fade_en),
        .i_fade_tick (w_fade_tick),
        .i_pwm_cnt   (r_pwm_cnt),
        .o_led       (led_out[gi])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_led_fade_driver.sv
// ============================================================================
// Module : tb_led_fade_driver
// Brief  : Self-checking bench for led_fade_driver against a cycle-count model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_led_fade_driver;

  localparam int NUM_LEDS = 8;
  localparam int PWM_BITS = 4;
  localparam int FADE_DIV = 4;
  localparam int MAXL     = 15;
  localparam int SLOW_DIV = 64;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NUM_LEDS-1:0] pattern_in;
  logic                fade_en;
  logic [NUM_LEDS-1:0] led_out;
  logic                slow_pattern;
  logic [0:0]          slow_led;

  always #5 clk = ~clk;

  led_fade_driver #(
    .NUM_LEDS (NUM_LEDS),
    .PWM_BITS (PWM_BITS),
    .FADE_DIV (FADE_DIV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pattern_in (pattern_in),
    .fade_en    (fade_en),
    .led_out    (led_out)
  );

  // Slow fade so a single level is held long enough to measure its duty.
  led_fade_driver #(
    .NUM_LEDS (1),
    .PWM_BITS (PWM_BITS),
    .FADE_DIV (SLOW_DIV)
  ) dut_slow (
    .clk        (clk),
    .reset_n    (reset_n),
    .pattern_in (slow_pattern),
    .fade_en    (fade_en),
    .led_out    (slow_led)
  );

  logic [PWM_BITS-1:0] probe [NUM_LEDS];
  generate
    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_probe
      assign probe[g] = dut.g_ch[g].u_ch.r_level;
    end
  endgenerate

  logic [PWM_BITS-1:0] slow_level;
  assign slow_level = dut_slow.g_ch[0].u_ch.r_level;

  int total = 0;
  int bad   = 0;
  int m_lvl [NUM_LEDS];
  logic [NUM_LEDS-1:0] m_led;
  int m_cyc;

  function automatic int duty(input int l);
`ifdef LED_FADE_GAMMA_EN
    return (l * l) >> PWM_BITS;
`else
    return l;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_LEDS; i++) m_lvl[i] = 0;
    m_led = '0;
    m_cyc = 0;
  endtask

  task automatic chk_state(input string tag);
    logic [31:0] obs_l, exp_l;
    for (int i = 0; i < NUM_LEDS; i++) begin
      obs_l[i*4 +: 4] = probe[i];
      exp_l[i*4 +: 4] = 4'(m_lvl[i]);
    end
    chk({tag, "_led"}, 64'(led_out), 64'(m_led));
    chk({tag, "_lvl"}, 64'(obs_l), 64'(exp_l));
  endtask

  // Model one clock edge: output uses pre-edge level and counter value.
  task automatic step();
    bit tick;
    @(posedge clk);
    for (int i = 0; i < NUM_LEDS; i++)
      m_led[i] = (m_lvl[i] == MAXL) || (duty(m_lvl[i]) > (m_cyc % (MAXL + 1)));
    tick = ((m_cyc % FADE_DIV) == FADE_DIV - 1);
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (pattern_in[i])                m_lvl[i] = MAXL;
      else if (!fade_en)                m_lvl[i] = 0;
      else if (tick && m_lvl[i] > 0)    m_lvl[i] = m_lvl[i] - 1;
    end
    m_cyc++;
    @(negedge clk);
    chk_state("step");
  endtask

  initial begin
    int cnt;
    reset_n      = 1'b0;
    pattern_in   = '0;
    fade_en      = 1'b0;
    slow_pattern = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_state("reset");
    reset_n = 1'b1;

    // Single channel held on
    pattern_in = 8'h01;
    fade_en    = 1'b1;
    step();
    step();
    chk("on_2nd_edge", 64'(led_out), 64'h01);
    repeat (14) step();

    // Fade from full to dark
    pattern_in = 8'h00;
    repeat (64) step();
    chk("fade_done_lvl0", 64'(probe[0]), 64'd0);
    cnt = 0;
    repeat (16) begin
      step();
      cnt += int'(led_out[0]);
    end
    chk("dark_after_fade", 64'(cnt), 64'd0);

    // Duty measurement at level 8 on the slow instance
    slow_pattern = 1'b1;
    repeat (2) step();
    slow_pattern = 1'b0;
    for (int k = 0; k < 2000 && slow_level != 4'd8; k++) step();
    chk("slow_reach_8", 64'(slow_level), 64'd8);
    cnt = 0;
    repeat (16) begin
      step();
      cnt += int'(slow_led[0]);
    end
    chk("duty_at_8", 64'(cnt), 64'(duty(8)));

    // Random patterns and fade enables
    repeat (300) begin
      if ($urandom_range(3, 0) == 0) pattern_in = 8'($urandom);
      fade_en = ($urandom_range(7, 0) != 0);
      step();
    end

    // Direct off: two-clock latency
    fade_en    = 1'b0;
    pattern_in = 8'hFF;
    repeat (3) step();
    pattern_in = 8'h00;
    step();
    chk("off_after_1", 64'(led_out), 64'hFF);
    step();
    chk("off_after_2", 64'(led_out), 64'h00);

    // Restart on channel 3 coincident with a fade tick at level 5
    fade_en    = 1'b1;
    pattern_in = 8'h08;
    repeat (2) step();
    pattern_in = 8'h00;
    for (int k = 0; k < 500 && !(m_lvl[3] == 5 && (m_cyc % FADE_DIV) == FADE_DIV - 1); k++)
      step();
    chk("restart_at_5", 64'(probe[3]), 64'd5);
    pattern_in = 8'h08;
    step();
    chk("restart_level", 64'(probe[3]), 64'd15);
    repeat (4) step();

    // Asynchronous reset mid-fade
    pattern_in = 8'hFF;
    repeat (3) step();
    pattern_in = 8'h00;
    repeat (10) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_led", 64'(led_out), 64'h00);
    model_reset();
    @(negedge clk);
    chk_state("in_reset");
    reset_n = 1'b1;
    chk_state("post_reset");
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_fade_driver.md
LED_FADE_DRIVER -- requirements
Module: led_fade_driver

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8: number of LED channels; equals the LED PIO output width.
REQ-002 SHALL have parameter PWM_BITS, default 4: brightness level width; MAX = 2^PWM_BITS-1.
REQ-003 SHALL have parameter FADE_DIV, default 4: clocks per fade step; legal range >= 1.
REQ-004 SHALL have port clk  input  1  system clock; the only clock.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pattern_in  input  NUM_LEDS  LED pattern from the LED PIO out_port, synchronous to clk.
REQ-007 SHALL have port fade_en  input  1  1 = trailing fade enabled; 0 = direct on/off.
REQ-008 SHALL have port led_out  output  NUM_LEDS  registered PWM drive to the board LED pins.

Function
REQ-009 SHALL run a free-running PWM_BITS-wide counter pwm_cnt, incrementing every clk and wrapping MAX->0.
REQ-010 SHALL run a prescaler counting 0..FADE_DIV-1, issuing a one-cycle fade_tick on the wrap to 0; FADE_DIV=1 gives a tick every clk.
REQ-011 SHALL hold one PWM_BITS-wide level per channel.
REQ-012 SHALL load level[i]=MAX at the clock edge where pattern_in[i]=1, regardless of fade_tick.
REQ-013 SHALL, with pattern_in[i]=0 and fade_en=1, decrement level[i] by 1 on each fade_tick while level[i]>0 and hold it at 0 (no wrap below 0).
REQ-014 SHALL, with pattern_in[i]=0 and fade_en=0, load level[i]=0 at the next edge.
REQ-015 SHALL register led_out[i] = 1 when level[i]==MAX, else (duty(level[i]) > pwm_cnt), where duty is defined in Configuration.
REQ-016 SHALL give a latency of exactly 2 clocks from a pattern_in change to the corresponding led_out effect (level update edge, then output register edge).
REQ-017 SHALL keep level 0 fully dark: led_out[i] stays 0 for every pwm_cnt value.
REQ-018 SHALL treat re-assertion of pattern_in[i] during a fade as a restart: the level returns to MAX at that edge; a fade_tick on the same edge is ignored.
REQ-019 SHALL operate every channel independently; the channels share only pwm_cnt and fade_tick.

Reset
REQ-020 SHALL asynchronously clear pwm_cnt, the prescaler, all levels and led_out to 0 while reset_n=0, including mid-fade.
REQ-021 SHALL resume counting from 0 on the first clk edge after reset_n deasserts.

Configuration
REQ-022 SHALL provide macro LED_FADE_GAMMA_EN.
REQ-023 SHALL, with LED_FADE_GAMMA_EN defined, use duty(level) = (level*level) >> PWM_BITS, computed at full 2*PWM_BITS width before the shift.
REQ-024 SHALL, with LED_FADE_GAMMA_EN undefined, use duty(level) = level (linear); the REQ-015 MAX override applies in both builds.

Structure
REQ-025 SHALL place the MAX level constant, the default PWM_BITS and the level type width in shared package led_fade_pkg.
REQ-026 SHALL implement per-channel level and compare logic in sub-module led_fade_channel, instantiated NUM_LEDS times by a generate loop; pwm_cnt and the prescaler stay in the top module.

Verification (NUM_LEDS=8, PWM_BITS=4, FADE_DIV=4, linear unless noted)
REQ-027 SHALL check: reset_n=0 asserted mid-fade -> led_out=0x00 immediately (asynchronous), and all levels are 0 after release.
REQ-028 SHALL check: pattern_in=0x01 held -> led_out[0]=1 continuously from the 2nd edge onward; led_out[7:1]=0.
REQ-029 SHALL check: pattern_in 0x01->0x00 with fade_en=1 -> level[0] steps 15->0, one step per 4 clocks; at level 8, led_out[0] is high 8 of 16 clocks; after 60 clocks led_out[0] stays 0.
REQ-030 SHALL check: fade_en=0 and pattern_in 0xFF->0x00 -> led_out=0x00 exactly 2 clocks later.
REQ-031 SHALL check: pattern_in[3] re-asserted at level 5, coincident with fade_tick -> level[3]=15 at that edge.
REQ-032 SHALL check: LED_FADE_GAMMA_EN build at level 8 -> duty 4 -> led_out high 4 of 16 clocks.
